// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit controller: opcode encodings,
// FSM state enum and default latencies.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MADD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_ctrl.sv
// Multi-cycle MIPS-style HI/LO multiply/divide controller with fixed-latency countdown.
// Optional multiply-accumulate (md_op 7) is built only when MDU_MADD_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------------
// ST_IDLE | accepts start; MTHI/MTLO write hi/lo directly, mul/div start busy
// ST_BUSY | countdown running; hi/lo frozen; shadow result commits at count 1
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [31:0]   sh_hi;
    logic [31:0]   sh_lo;

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic               div_ovf;

    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic [CW-1:0] res_lat;
    logic          res_go;

    assign a_sx    = {{32{A[31]}}, A};
    assign b_sx    = {{32{B[31]}}, B};
    assign prod_s  = a_sx * b_sx;
    assign prod_u  = {32'd0, A} * {32'd0, B};
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    // Most-negative / -1 is pinned explicitly rather than relying on tool overflow behaviour.
    always_comb begin
        quo_s = 32'd0;
        rem_s = 32'd0;
        quo_u = 32'd0;
        rem_u = 32'd0;
        if (B != 32'd0) begin
            quo_u = A / B;
            rem_u = A % B;
            if (div_ovf) begin
                quo_s = 32'h8000_0000;
                rem_s = 32'd0;
            end else begin
                quo_s = $signed(A) / $signed(B);
                rem_s = $signed(A) % $signed(B);
            end
        end
    end

`ifdef MDU_MADD_EN
    logic [63:0] madd_sum;
    assign madd_sum = {hi, lo} + prod_s;
`endif

    always_comb begin
        res_hi  = hi;
        res_lo  = lo;
        res_lat = CW'(MULT_CYCLES);
        res_go  = 1'b0;
        case (md_op)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_go = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_go = 1'b1;
            end
            // Divide by zero still runs the full latency but recommits the current hi/lo.
            OP_DIV: begin
                if (B != 32'd0) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
                res_lat = CW'(DIV_CYCLES);
                res_go  = 1'b1;
            end
            OP_DIVU: begin
                if (B != 32'd0) begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
                res_lat = CW'(DIV_CYCLES);
                res_go  = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                {res_hi, res_lo} = madd_sum;
                res_go = 1'b1;
            end
`endif
            default: res_go = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            sh_hi <= 32'd0;
            sh_lo <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (res_go) begin
                            sh_hi <= res_hi;
                            sh_lo <= res_lo;
                            cnt   <= res_lat;
                            busy  <= 1'b1;
                            state <= ST_BUSY;
                        end else if (md_op == OP_MTHI) begin
                            hi <= A;
                        end else if (md_op == OP_MTLO) begin
                            lo <= A;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == CW'(1)) begin
                        hi    <= sh_hi;
                        lo    <= sh_lo;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: table of directed ops plus hand-written
// sequences for start-while-busy and reset-mid-operation.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge (busy cycle 1).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        issue(v.op, v.a, v.b);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            chk({v.name, " hold hi"}, {32'd0, hi}, {32'd0, prev_hi});
            chk({v.name, " hold lo"}, {32'd0, lo}, {32'd0, prev_lo});
            n++;
            @(negedge clk);
        end
        chk({v.name, " latency"}, 64'(n), 64'(v.lat));
        chk({v.name, " busy low"}, {63'd0, busy}, 64'd0);
        chk({v.name, " hi"}, {32'd0, hi}, {32'd0, v.exp_hi});
        chk({v.name, " lo"}, {32'd0, lo}, {32'd0, v.exp_lo});
        prev_hi = v.exp_hi;
        prev_lo = v.exp_lo;
    endtask

    initial begin
        int n;

        vt[0]  = '{"mthi",      OP_MTHI,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'h0000_0000, 0};
        vt[1]  = '{"mtlo",      OP_MTLO,  32'h0000_5678, 32'd0,         32'h0000_1234, 32'h0000_5678, 0};
        vt[2]  = '{"div_by0",   OP_DIV,   32'd5,         32'd0,         32'h0000_1234, 32'h0000_5678, 10};
        vt[3]  = '{"mult_neg",  OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vt[4]  = '{"divu_7_2",  OP_DIVU,  32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 10};
        vt[5]  = '{"div_m7_2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vt[6]  = '{"div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vt[7]  = '{"multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vt[8]  = '{"none",      OP_NONE,  32'd9,         32'd9,         32'hFFFF_FFFE, 32'h0000_0001, 0};
        vt[9]  = '{"mult_2p32", OP_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
        vt[10] = '{"div_7_m2",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vt[11] = '{"mthi0",     OP_MTHI,  32'd0,         32'd0,         32'h0000_0000, 32'hFFFF_FFFD, 0};
        vt[12] = '{"mtlo10",    OP_MTLO,  32'd10,        32'd0,         32'h0000_0000, 32'h0000_000A, 0};
`ifdef MDU_MADD_EN
        vt[13] = '{"madd_4_5",  OP_MADD,  32'd4,         32'd5,         32'h0000_0000, 32'h0000_001E, 5};
        vt[14] = '{"madd_wrap", OP_MADD,  32'hFFFF_FFFF, 32'd31,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 5};
`else
        vt[13] = '{"madd_4_5",  OP_MADD,  32'd4,         32'd5,         32'h0000_0000, 32'h0000_000A, 0};
        vt[14] = '{"madd_wrap", OP_MADD,  32'hFFFF_FFFF, 32'd31,        32'h0000_0000, 32'h0000_000A, 0};
`endif

        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);
        reset   = 1'b0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_vec(vt[i]);
        end

        // MTLO in busy cycle 2 and MTHI in the completion cycle must both be dropped.
        issue(OP_MULT, 32'd7, 32'd6);
        for (int c = 1; c <= 5; c++) begin
            chk("ign busy high", {63'd0, busy}, 64'd1);
            if (c == 2) begin
                start = 1'b1; md_op = OP_MTLO; A = 32'h0000_AAAA;
            end else if (c == 5) begin
                start = 1'b1; md_op = OP_MTHI; A = 32'h0000_BEEF;
            end else begin
                start = 1'b0; md_op = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        md_op = 3'd0;
        chk("ign busy low", {63'd0, busy}, 64'd0);
        chk("ign hi", {32'd0, hi}, 64'd0);
        chk("ign lo", {32'd0, lo}, 64'd42);
        @(negedge clk);
        chk("ign hi after", {32'd0, hi}, 64'd0);

        // Reset in busy cycle 3 of a divide aborts it and clears hi/lo.
        issue(OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        chk("rst pre busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst hi", {32'd0, hi}, 64'd0);
        chk("rst lo", {32'd0, lo}, 64'd0);
        repeat (12) @(negedge clk);
        chk("rst no commit lo", {32'd0, lo}, 64'd0);
        chk("rst no commit busy", {63'd0, busy}, 64'd0);

        issue(OP_MULT, 32'd2, 32'd3);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("post rst latency", 64'(n), 64'd5);
        chk("post rst hi", {32'd0, hi}, 64'd0);
        chk("post rst lo", {32'd0, lo}, 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, number of busy cycles for MULT/MULTU/MADD.
REQ-002 Parameter DIV_CYCLES, default 10, number of busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  one-cycle request qualifying md_op.
REQ-006 md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD.
REQ-007 A  input  32  operand 1 (rs), dividend, or MTHI/MTLO source.
REQ-008 B  input  32  operand 2 (rt), divisor.
REQ-009 busy  output  1  high while a multiply/divide is in flight.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.

Function
REQ-012 The FSM SHALL have two states: IDLE and BUSY.
REQ-013 In IDLE, start with md_op 1-4 SHALL latch the full result into shadow registers, load the countdown counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-014 busy SHALL be 1 exactly for cycles t+1..t+N after a start accepted at edge t, with N the op latency.
REQ-015 HI/LO SHALL update from the shadow registers at the edge ending cycle t+N, visible in cycle t+N+1 with busy=0; the FSM SHALL return to IDLE on that edge.
REQ-016 hi/lo SHALL hold their previous values throughout BUSY.
REQ-017 MULT: {hi,lo} = signed A*B (64 bit); MULTU: unsigned A*B.
REQ-018 DIV: lo = signed A/B truncated toward zero, hi = remainder with sign of A; DIVU unsigned.
REQ-019 Divide with B=0 SHALL still take DIV_CYCLES and leave hi and lo unchanged.
REQ-020 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-021 MTHI/MTLO in IDLE SHALL write A to hi/lo at the same edge, with no busy cycle.
REQ-022 Any start, including MTHI/MTLO, SHALL be ignored while busy=1 or during the completion edge.
REQ-023 start with md_op=0, or md_op=7 without the macro, SHALL be a no-op.

Reset
REQ-024 reset SHALL force state IDLE, counter 0, busy 0, hi 0, lo 0, shadow registers 0.
REQ-025 reset SHALL take priority over start and over completion; reset mid-BUSY aborts the op and commits no result.

Configuration
REQ-026 With MDU_MADD_EN defined, md_op 7 SHALL perform {hi,lo} += signed A*B (modulo 2^64), using the hi/lo values at acceptance, with MULT_CYCLES latency.
REQ-027 Without MDU_MADD_EN, md_op 7 SHALL be treated as NONE and the accumulate logic SHALL be absent.

Structure
REQ-028 Package mdu_pkg SHALL hold the md_op encodings, the state enum, and the default latency constants.
REQ-029 No sub-module SHALL be used; the arithmetic is inline combinational logic feeding the shadow registers.

Verification
REQ-030 MULT A=0xFFFFFFFE (-2), B=3 -> busy cycles 1-5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 DIVU A=7, B=2 -> busy for 10 cycles, then lo=3, hi=1; DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 DIV B=0 after MTHI 0x1234 and MTLO 0x5678 -> busy for 10 cycles, then hi=0x1234, lo=0x5678.
REQ-033 MULT accepted, MTLO 0xAAAA issued in busy cycle 2 -> MTLO ignored; lo equals the product after completion.
REQ-034 reset asserted in busy cycle 3 of DIV -> next cycle busy=0, hi=0, lo=0; a following MULT 2*3 gives lo=6.
REQ-035 With MDU_MADD_EN: after MTLO 10, MADD 4*5 -> lo=30, hi=0; without the macro -> lo=10 and busy never rises.
